match_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pattern-match engine among NREQ requesters. It grants the engine to one requester at a time and drives the engine's start pulse and base address. It waits for the engine's done flag, or aborts on a timeout, and returns the match address to the granted requester with a one-cycle response strobe. It sits between the requester clients and the engine FSM's start/done_flag/match_address port.

---
 rtl/match_arbiter.sv | 148 ++++++++++++++
 tb/tb_match_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_arbiter.sv
// Round-robin arbiter/sequencer sharing one pattern-match engine among NREQ
// requesters: grant, start pulse, wait for done or timeout, respond.
module match_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int AW      = 9,
  parameter  int TIMEOUT = 500,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_base,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               eng_start,
  output logic [AW-1:0]      eng_base,
  output logic               eng_abort,
  input  logic               eng_done,
  input  logic [AW-1:0]      eng_match_address,
  output logic               resp_valid,
  output logic [IW-1:0]      resp_id,
  output logic [AW-1:0]      resp_address,
  output logic               resp_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [NREQ-1:0] ONE     = NREQ'(1);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d, win;
  logic [15:0]     cnt, cnt_d;
  logic [NREQ-1:0] grant_d;
  logic            busy_d, start_d, abort_d, valid_d, to_d;
  logic [AW-1:0]   base_d, addr_d;
  logic [IW-1:0]   id_d;

  // First set request bit strictly after p, wrapping; the last owner is
  // therefore always considered last.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
    logic [IW-1:0] w;
    logic [IW-1:0] idx;
    logic          found;
    w     = p;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(p) + k) % NREQ);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    grant_d = grant;
    busy_d  = busy;
    start_d = 1'b0;
    abort_d = 1'b0;
    valid_d = 1'b0;
    base_d  = eng_base;
    addr_d  = resp_address;
    id_d    = resp_id;
    to_d    = resp_timeout;
    win     = rr_pick(req, ptr);
    case (state)
      S_IDLE: begin
        if (|req) begin
          grant_d = ONE << win;
          for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) base_d = req_base[i*AW +: AW];
          end
          ptr_d   = win;
          busy_d  = 1'b1;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a coincident timeout
        if (eng_done) begin
          addr_d  = eng_match_address;
          to_d    = 1'b0;
          id_d    = ptr;
          valid_d = 1'b1;
          state_d = S_RESP;
        end else if (cnt == TO_LAST) begin
          addr_d  = '0;
          to_d    = 1'b1;
          id_d    = ptr;
          valid_d = 1'b1;
          abort_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_RESP: begin
        grant_d = '0;
        busy_d  = 1'b0;
        base_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= IW'(NREQ - 1);
      cnt          <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      eng_start    <= 1'b0;
      eng_abort    <= 1'b0;
      eng_base     <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_address <= '0;
      resp_timeout <= 1'b0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      cnt          <= cnt_d;
      grant        <= grant_d;
      busy         <= busy_d;
      eng_start    <= start_d;
      eng_abort    <= abort_d;
      eng_base     <= base_d;
      resp_valid   <= valid_d;
      resp_id      <= id_d;
      resp_address <= addr_d;
      resp_timeout <= to_d;
    end
  end

endmodule

// File: tb/tb_match_arbiter.sv
// Bench for match_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a search-age model.
module tb_match_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 9;
  localparam int TIMEOUT = 8;
  localparam int IW      = 2;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic               clock;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_base;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               eng_start;
  logic [AW-1:0]      eng_base;
  logic               eng_abort;
  logic               eng_done;
  logic [AW-1:0]      eng_match_address;
  logic               resp_valid;
  logic [IW-1:0]      resp_id;
  logic [AW-1:0]      resp_address;
  logic               resp_timeout;

  match_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_base(req_base),
    .grant(grant), .busy(busy), .eng_start(eng_start), .eng_base(eng_base),
    .eng_abort(eng_abort), .eng_done(eng_done),
    .eng_match_address(eng_match_address), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_address(resp_address),
    .resp_timeout(resp_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Engine emulation: directed mode raises done in the delay-th WAIT cycle
  // (optionally also during ISSUE); random mode toggles done freely.
  int            eng_mode   = 0;
  int            delay      = -1;
  int            issue_done = 0;
  logic [AW-1:0] eng_addr   = '0;
  int            wcnt       = 0;

  always @(negedge clock) begin
    logic [31:0] rnd;
    if (eng_mode == 1) begin
      eng_done          = ($urandom % 4 == 0);
      rnd               = $urandom;
      eng_match_address = rnd[AW-1:0];
    end else begin
      eng_match_address = eng_addr;
      if (eng_start === 1'b1) begin
        wcnt     = 0;
        eng_done = (issue_done != 0);
      end else if (busy === 1'b1 && resp_valid !== 1'b1) begin
        wcnt++;
        eng_done = (wcnt == delay);
      end else begin
        eng_done = 1'b0;
      end
    end
  end

  // Model: a search is tracked by its age (0 = grant cycle in IDLE,
  // 1 = start pulse, 2.. = waiting) and the age at which it responds.
  int            owner   = -1;
  int            age     = 0;
  int            resp_at = -1;
  int            m_ptr   = NREQ - 1;
  int            m_id    = 0;
  logic [AW-1:0] m_base  = '0;
  logic [AW-1:0] m_addr  = '0;
  logic          m_to    = 1'b0;
  bit            armed   = 1'b0;

  always @(posedge clock) begin
    logic [NREQ*AW-1:0] sh;
    logic [NREQ-1:0]    eg;
    logic               ev;
    cyc++;
    if (reset === 1'b1) begin
      owner = -1; m_ptr = NREQ - 1; m_id = 0; m_addr = '0; m_to = 1'b0;
      armed = 1'b1;
    end else if (owner < 0) begin
      if (req != 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (owner < 0 && ((req >> i) & ONE) != 0) owner = i;
        end
        m_ptr   = owner;
        age     = 1;
        resp_at = -1;
        sh      = req_base >> (owner * AW);
        m_base  = sh[AW-1:0];
      end
    end else begin
      if (age >= 2 && resp_at < 0) begin
        if (eng_done === 1'b1) begin
          resp_at = age + 1; m_addr = eng_match_address; m_to = 1'b0; m_id = owner;
        end else if (age == 1 + TIMEOUT) begin
          resp_at = age + 1; m_addr = '0; m_to = 1'b1; m_id = owner;
        end
      end
      if (age == resp_at) owner = -1;
      else age++;
    end
    #1;
    if (armed) begin
      eg = (owner < 0) ? '0 : (ONE << owner);
      ev = (owner >= 0) && (age == resp_at);
      check("grant",        32'(grant),        32'(eg));
      check("busy",         32'(busy),         32'(owner >= 0));
      check("eng_start",    32'(eng_start),    32'((owner >= 0) && (age == 1)));
      check("eng_base",     32'(eng_base),     (owner < 0) ? 32'd0 : 32'(m_base));
      check("resp_valid",   32'(resp_valid),   32'(ev));
      check("eng_abort",    32'(eng_abort),    32'(ev && m_to));
      check("resp_id",      32'(resp_id),      32'(m_id));
      check("resp_address", 32'(resp_address), 32'(m_addr));
      check("resp_timeout", 32'(resp_timeout), 32'(m_to));
    end
  end

  // which: 0 = eng_start, 1 = resp_valid; at = cycle seen, -1 on expiry
  task automatic wait_for(input int which, input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      if ((which == 0 && eng_start === 1'b1) ||
          (which == 1 && resp_valid === 1'b1)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      $display("FAIL wait%0d: no event within %0d cycles", which, limit);
    end
  endtask

  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int ts, tr;
    logic [63:0] r64;
    reset = 1'b1; req = '0; req_base = '0;
    eng_done = 1'b0; eng_match_address = '0;
    repeat (2) @(negedge clock);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_resp",  32'(resp_valid), 32'd0);
    reset = 1'b0;

    // single request
    req_base[0*AW +: AW] = 9'h055; delay = 3; eng_addr = 9'h1A3; req = 4'b0001;
    wait_for(0, 20, ts);
    check("t1_base", 32'(eng_base), 32'h055);
    wait_for(1, 20, tr);
    check("t1_lat",  32'(tr - ts), 32'd4);
    check("t1_id",   32'(resp_id), 32'd0);
    check("t1_addr", 32'(resp_address), 32'h1A3);
    check("t1_to",   32'(resp_timeout), 32'd0);
    req = '0;
    @(negedge clock);
    check("t1_grant_off", 32'(grant), 32'd0);
    check("t1_valid_off", 32'(resp_valid), 32'd0);

    // round-robin from reset
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    delay = 2; req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_for(1, 30, tr);
      check("rr_id", 32'(resp_id), 32'(exp_rr[i]));
    end
    req = '0;
    @(negedge clock);

    // timeout
    delay = -1; req = 4'b0100;
    wait_for(0, 20, ts);
    wait_for(1, 40, tr);
    check("to_lat",   32'(tr - ts), 32'd9);
    check("to_abort", 32'(eng_abort), 32'd1);
    check("to_id",    32'(resp_id), 32'd2);
    check("to_flag",  32'(resp_timeout), 32'd1);
    check("to_addr",  32'(resp_address), 32'd0);
    req = '0;
    @(negedge clock);

    // done during ISSUE is ignored
    issue_done = 1; delay = 2; eng_addr = 9'h0C7; req = 4'b0001;
    wait_for(0, 20, ts);
    wait_for(1, 20, tr);
    check("iss_lat",  32'(tr - ts), 32'd3);
    check("iss_addr", 32'(resp_address), 32'h0C7);
    issue_done = 0; req = '0;
    @(negedge clock);

    // done on the final timeout cycle wins
    delay = TIMEOUT; eng_addr = 9'h0AB; req = 4'b1000;
    wait_for(0, 20, ts);
    wait_for(1, 40, tr);
    check("coin_lat",   32'(tr - ts), 32'd9);
    check("coin_to",    32'(resp_timeout), 32'd0);
    check("coin_addr",  32'(resp_address), 32'h0AB);
    check("coin_abort", 32'(eng_abort), 32'd0);
    check("coin_id",    32'(resp_id), 32'd3);
    req = '0;
    @(negedge clock);

    // reset mid-search
    delay = -1; req = 4'b0010;
    wait_for(0, 20, ts);
    repeat (2) @(negedge clock);
    reset = 1'b1; req = '0;
    @(negedge clock);
    reset = 1'b0;
    check("mr_grant", 32'(grant), 32'd0);
    check("mr_busy",  32'(busy), 32'd0);
    check("mr_addr",  32'(resp_address), 32'd0);
    repeat (4) @(negedge clock);
    delay = 2; req = 4'b0010;
    wait_for(0, 20, ts);
    check("mr_regrant", 32'(grant), 32'h2);
    wait_for(1, 20, tr);
    check("mr_id", 32'(resp_id), 32'd1);
    req = '0;
    @(negedge clock);

    // withdrawal and base change during WAIT
    req_base[1*AW +: AW] = 9'h1F0; delay = 4; eng_addr = 9'h111; req = 4'b0010;
    wait_for(0, 20, ts);
    @(negedge clock);
    req = '0; req_base[1*AW +: AW] = 9'h00F;
    wait_for(1, 20, tr);
    check("wd_id",   32'(resp_id), 32'd1);
    check("wd_base", 32'(eng_base), 32'h1F0);
    check("wd_addr", 32'(resp_address), 32'h111);
    @(negedge clock);

    // randomized traffic
    eng_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset = ($urandom % 400 == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (((req >> i) & ONE) != 0) begin
          if ((resp_valid === 1'b1 && int'(resp_id) == i && $urandom % 2 == 0) ||
              (((grant >> i) & ONE) != 0 && $urandom % 8 == 0))
            req = req & ~(ONE << i);
        end else if ($urandom % 3 == 0) begin
          req = req | (ONE << i);
        end
      end
      r64 = {$urandom, $urandom};
      req_base = r64[NREQ*AW-1:0];
    end
    reset = 1'b0; req = '0; eng_mode = 0;
    repeat (20) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
